// File: rtl/vga_pattern_renderer_if.sv
// Video bus between the sync/counter stage and the pattern renderer:
// timing inputs (syncs + raw counts) and the registered RGB/sync outputs.
interface vga_pattern_renderer_if;
    logic        hsynq_in;
    logic        vsynq_in;
    logic [15:0] haddress;
    logic [15:0] vaddress;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsynq_out;
    logic        vsynq_out;

    modport master (
        output hsynq_in, vsynq_in, haddress, vaddress,
        input  red, green, blue, hsynq_out, vsynq_out
    );

    modport slave (
        input  hsynq_in, vsynq_in, haddress, vaddress,
        output red, green, blue, hsynq_out, vsynq_out
    );
endinterface

// File: rtl/vga_pattern_renderer.sv
// Two-stage VGA test-pattern renderer (bars / checker / bouncing box) with a frame-synchronous mode FSM.
// Optional white one-pixel border around the active area when VGA_BORDER_EN is defined.
module vga_pattern_renderer #(
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int BOX_SIZE    = 32,
    parameter int BOX_STEP    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic        mode_next,
    vga_pattern_renderer_if.slave vid,
    output logic [1:0]  mode,
    output logic [15:0] frame_count,
    output logic [9:0]  box_x,
    output logic [8:0]  box_y,
    output logic        box_right,
    output logic        box_down
);
    typedef enum logic [1:0] {BARS = 2'd0, CHECKER = 2'd1, BOX = 2'd2} mode_t;

    localparam logic [15:0] H_LO  = 16'(H_ACT_START);
    localparam logic [15:0] H_HI  = 16'(H_ACT_START + H_ACTIVE);
    localparam logic [15:0] V_LO  = 16'(V_ACT_START);
    localparam logic [15:0] V_HI  = 16'(V_ACT_START + V_ACTIVE);
    localparam logic [9:0]  X_OFF = 10'(H_ACT_START);
    localparam logic [8:0]  Y_OFF = 9'(V_ACT_START);

    mode_t state;
    logic  pending;
    logic  tick;

    logic       s1_active, s1_hs, s1_vs;
    logic [9:0] s1_x;
    logic [8:0] s1_y;
    logic [2:0] bar_idx;
    logic [11:0] colour;
    logic       in_box;

    assign tick = pix_ce && (vid.haddress == 16'd0) && (vid.vaddress == 16'd0);
    assign mode = state;

    // Requests latch into pending; only one step is taken per frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BARS;
            pending <= 1'b0;
        end else if (pix_ce) begin
            if (tick) begin
                pending <= 1'b0;
                if (pending || mode_next) begin
                    case (state)
                        BARS:    state <= CHECKER;
                        CHECKER: state <= BOX;
                        default: state <= BARS;
                    endcase
                end else if (!(state inside {BARS, CHECKER, BOX})) begin
                    state <= BARS;
                end
            end else begin
                if (mode_next) pending <= 1'b1;
                if (!(state inside {BARS, CHECKER, BOX})) state <= BARS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= 16'd0;
            box_x       <= 10'd0;
            box_y       <= 9'd0;
            box_right   <= 1'b1;
            box_down    <= 1'b1;
        end else if (tick) begin
            frame_count <= frame_count + 16'd1;
            if (box_right) begin
                if ({1'b0, box_x} + 11'(BOX_SIZE + BOX_STEP) > 11'(H_ACTIVE)) begin
                    box_x     <= 10'(H_ACTIVE - BOX_SIZE);
                    box_right <= 1'b0;
                end else begin
                    box_x <= box_x + 10'(BOX_STEP);
                end
            end else if (box_x < 10'(BOX_STEP)) begin
                box_x     <= 10'd0;
                box_right <= 1'b1;
            end else begin
                box_x <= box_x - 10'(BOX_STEP);
            end
            if (box_down) begin
                if ({1'b0, box_y} + 10'(BOX_SIZE + BOX_STEP) > 10'(V_ACTIVE)) begin
                    box_y    <= 9'(V_ACTIVE - BOX_SIZE);
                    box_down <= 1'b0;
                end else begin
                    box_y <= box_y + 9'(BOX_STEP);
                end
            end else if (box_y < 9'(BOX_STEP)) begin
                box_y    <= 9'd0;
                box_down <= 1'b1;
            end else begin
                box_y <= box_y - 9'(BOX_STEP);
            end
        end
    end

    // Stage 1: active window and pixel coordinates relative to the visible origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active <= 1'b0;
            s1_x      <= 10'd0;
            s1_y      <= 9'd0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
        end else if (pix_ce) begin
            s1_active <= (vid.haddress >= H_LO) && (vid.haddress < H_HI) &&
                         (vid.vaddress >= V_LO) && (vid.vaddress < V_HI);
            s1_x      <= vid.haddress[9:0] - X_OFF;
            s1_y      <= vid.vaddress[8:0] - Y_OFF;
            s1_hs     <= vid.hsynq_in;
            s1_vs     <= vid.vsynq_in;
        end
    end

    always_comb begin
        bar_idx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (s1_x < 10'(80 * (i + 1))) bar_idx = 3'(i);
        end
    end

    assign in_box = ({1'b0, s1_x} >= {1'b0, box_x}) &&
                    ({1'b0, s1_x} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
                    ({1'b0, s1_y} >= {1'b0, box_y}) &&
                    ({1'b0, s1_y} <  {1'b0, box_y} + 10'(BOX_SIZE));

    always_comb begin
        colour = 12'h000;
        case (state)
            BARS: begin
                case (bar_idx)
                    3'd0:    colour = 12'hFFF;
                    3'd1:    colour = 12'hFF0;
                    3'd2:    colour = 12'h0FF;
                    3'd3:    colour = 12'h0F0;
                    3'd4:    colour = 12'hF0F;
                    3'd5:    colour = 12'hF00;
                    3'd6:    colour = 12'h00F;
                    default: colour = 12'h000;
                endcase
            end
            CHECKER: colour = (s1_x[5] ^ s1_y[5]) ? 12'hFFF : 12'h000;
            BOX:     colour = in_box ? 12'hF00 : 12'h004;
            default: colour = 12'h000;
        endcase
`ifdef VGA_BORDER_EN
        if ((s1_x == 10'd0) || (s1_x == 10'(H_ACTIVE - 1)) ||
            (s1_y == 9'd0)  || (s1_y == 9'(V_ACTIVE - 1)))
            colour = 12'hFFF;
`else
`endif
    end

    // Stage 2: registered colour; syncs ride along so they stay aligned with RGB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.red       <= 4'h0;
            vid.green     <= 4'h0;
            vid.blue      <= 4'h0;
            vid.hsynq_out <= 1'b1;
            vid.vsynq_out <= 1'b1;
        end else if (pix_ce) begin
            {vid.red, vid.green, vid.blue} <= s1_active ? colour : 12'h000;
            vid.hsynq_out <= s1_hs;
            vid.vsynq_out <= s1_vs;
        end
    end
endmodule
